soi_probe_arbiter: RTL and testbench

Shares one signal-of-interest (SOI) sampling channel among NUM_REQ requesters. Each requester asks for a sample of one SOI, selected by address. The arbiter picks one request in round-robin order and issues it to the channel. It then waits for the channel response under a timeout and returns the sampled value, or an error, to the winning requester only. It sits between observation clients and the DPI-backed SOI query path in the SysObs testbench fabric, and is fully synthesizable.

---
 rtl/soi_probe_arbiter.sv | 179 +++++++++++++++++
 tb/tb_soi_probe_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/soi_probe_arbiter.sv
// soi_probe_arbiter: round-robin sharing of one SOI sampling channel among
// NUM_REQ requesters. Each transaction issues one sample request, waits for
// the channel response under a timeout, and returns the value (or a timeout
// error) to the winning requester as a one-cycle pulse.
module soi_probe_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  output logic                      chan_valid_o,
  output logic [ADDR_W-1:0]         chan_addr_o,
  input  logic                      chan_ready_i,
  input  logic                      chan_rsp_valid_i,
  input  logic [DATA_W-1:0]         chan_rsp_data_i,
  output logic [NUM_REQ-1:0]        rsp_valid_o,
  output logic [DATA_W-1:0]         rsp_data_o,
  output logic                      rsp_err_o,
  output logic                      busy_o
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  // The timer reads 0 in the first ISSUE cycle, so expiry is flagged once it
  // has counted TIMEOUT cycles; the response pulse then lands TIMEOUT+1 cycles
  // after the first ISSUE cycle. The counter saturates at this value.
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              state_reg;
  state_t              state_next;
  logic [IDX_W-1:0]    idx_reg;
  logic [IDX_W-1:0]    last_grant_reg;
  logic [IDX_W-1:0]    pick_idx;
  logic                pick_found;
  logic [ADDR_W-1:0]   addr_reg;
  logic [TMR_W-1:0]    timer_reg;
  logic                expired;
  logic [NUM_REQ-1:0]  idx_onehot;
  logic [NUM_REQ-1:0]  rsp_valid_reg;
  logic [DATA_W-1:0]   rsp_data_reg;
  logic                rsp_err_reg;
  logic [DATA_W-1:0]   done_data;
  logic                done_err;
  logic [ADDR_W-1:0]   req_addr_arr [NUM_REQ];

  // Unpack per-requester addresses and decode the latched winner to one-hot.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign req_addr_arr[gi] = req_addr_i[gi*ADDR_W +: ADDR_W];
      assign idx_onehot[gi]   = (idx_reg == IDX_W'(gi));
    end
  endgenerate

  assign expired = (timer_reg == TMR_LAST);

  // Round-robin pick: first set request searching upward from last_grant+1.
  always_comb begin
    int               cand;
    logic [IDX_W-1:0] cand_idx;
    pick_idx   = last_grant_reg;
    pick_found = 1'b0;
    cand       = 0;
    cand_idx   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = int'(last_grant_reg) + i;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      cand_idx = IDX_W'(cand);
      if (!pick_found && req_i[cand_idx]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  // Next-state logic; also captures the completion payload when entering DONE.
  always_comb begin
    state_next = state_reg;
    done_data  = '0;
    done_err   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (pick_found) begin
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        // An accept wins over a simultaneous expiry; expiry then hits in WAIT.
        if (chan_ready_i) begin
          state_next = WAIT;
        end else if (expired) begin
          state_next = DONE;
          done_err   = 1'b1;
        end
      end
      WAIT: begin
        // A response wins over a simultaneous expiry.
        if (chan_rsp_valid_i) begin
          state_next = DONE;
          done_data  = chan_rsp_data_i;
        end else if (expired) begin
          state_next = DONE;
          done_err   = 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Winner latch, saturating transaction timer and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_reg        <= '0;
      addr_reg       <= '0;
      timer_reg      <= '0;
      last_grant_reg <= IDX_W'(NUM_REQ - 1);
    end else begin
      if (state_reg == IDLE) begin
        timer_reg <= '0;
        if (pick_found) begin
          idx_reg  <= pick_idx;
          addr_reg <= req_addr_arr[pick_idx];
        end
      end else if ((state_reg == ISSUE || state_reg == WAIT) && !expired) begin
        timer_reg <= timer_reg + 1'b1;
      end
      if (state_reg == DONE) begin
        last_grant_reg <= idx_reg;
      end
    end
  end

  // Registered completion outputs: nonzero only during the DONE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_reg <= '0;
      rsp_data_reg  <= '0;
      rsp_err_reg   <= 1'b0;
    end else begin
      rsp_valid_reg <= (state_next == DONE) ? idx_onehot : '0;
      rsp_data_reg  <= done_data;
      rsp_err_reg   <= done_err;
    end
  end

  assign chan_valid_o = (state_reg == ISSUE);
  assign chan_addr_o  = chan_valid_o ? addr_reg : '0;
  assign busy_o       = (state_reg != IDLE);
  assign rsp_valid_o  = rsp_valid_reg;
  assign rsp_data_o   = rsp_data_reg;
  assign rsp_err_o    = rsp_err_reg;

endmodule

// File: tb/tb_soi_probe_arbiter.sv
// Scoreboard bench for soi_probe_arbiter: expected completions are queued as
// each transaction is driven and checked when the DUT pulses rsp_valid_o.
module tb_soi_probe_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 4;
  localparam int DATA_W  = 8;
  localparam int TIMEOUT = 15;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NUM_REQ-1:0]        req_i;
  logic [NUM_REQ*ADDR_W-1:0] req_addr_i;
  logic                      chan_valid_o;
  logic [ADDR_W-1:0]         chan_addr_o;
  logic                      chan_ready_i;
  logic                      chan_rsp_valid_i;
  logic [DATA_W-1:0]         chan_rsp_data_i;
  logic [NUM_REQ-1:0]        rsp_valid_o;
  logic [DATA_W-1:0]         rsp_data_o;
  logic                      rsp_err_o;
  logic                      busy_o;

  soi_probe_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .req_i            (req_i),
    .req_addr_i       (req_addr_i),
    .chan_valid_o     (chan_valid_o),
    .chan_addr_o      (chan_addr_o),
    .chan_ready_i     (chan_ready_i),
    .chan_rsp_valid_i (chan_rsp_valid_i),
    .chan_rsp_data_i  (chan_rsp_data_i),
    .rsp_valid_o      (rsp_valid_o),
    .rsp_data_o       (rsp_data_o),
    .rsp_err_o        (rsp_err_o),
    .busy_o           (busy_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_total = 0;
  int n_bad   = 0;

  typedef struct {
    logic [NUM_REQ-1:0] v;
    logic [DATA_W-1:0]  d;
    logic               e;
    int                 at;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Completion monitor: pops the scoreboard on every response pulse.
  always @(negedge clk) begin
    if (rsp_valid_o !== '0) begin
      if (sb.size() == 0) begin
        chk("rsp_unexpected", 32'(rsp_valid_o), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("rsp_vec",   32'(rsp_valid_o), 32'(mon_e.v));
        chk("rsp_data",  32'(rsp_data_o),  32'(mon_e.d));
        chk("rsp_err",   32'(rsp_err_o),   32'(mon_e.e));
        chk("rsp_cycle", 32'(cyc),         32'(mon_e.at));
        $display("txn rsp_valid=%b data=%h err=%b cycle=%0d", rsp_valid_o, rsp_data_o, rsp_err_o, cyc);
      end
    end
  end

  task automatic wait_valid();
    int n;
    n = 0;
    while (chan_valid_o !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("issue_seen", 32'(chan_valid_o), 32'd1);
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_chan_valid"}, 32'(chan_valid_o), 32'd0);
    chk({tag, "_chan_addr"},  32'(chan_addr_o),  32'd0);
    chk({tag, "_rsp_valid"},  32'(rsp_valid_o),  32'd0);
    chk({tag, "_rsp_data"},   32'(rsp_data_o),   32'd0);
    chk({tag, "_rsp_err"},    32'(rsp_err_o),    32'd0);
    chk({tag, "_busy"},       32'(busy_o),       32'd0);
  endtask

  // Plays the channel for one transaction and queues the expected completion.
  // Returns at the negedge of the expected DONE cycle; ci is the first ISSUE cycle.
  task automatic serve(input int exp_idx, input logic [ADDR_W-1:0] exp_addr,
                       input int ready_lat, input int rsp_lat, input bit respond,
                       input logic [DATA_W-1:0] d, output int ci);
    logic [NUM_REQ-1:0] oh;
    oh = '0;
    oh[exp_idx] = 1'b1;
    wait_valid();
    ci = cyc;
    if (chan_valid_o !== 1'b1) return;
    chk("chan_addr", 32'(chan_addr_o), 32'(exp_addr));
    chan_ready_i = (ready_lat == 0);
    for (int i = 0; i < ready_lat; i++) begin
      tick();
      chk("valid_held",  32'(chan_valid_o), 32'd1);
      chk("addr_stable", 32'(chan_addr_o),  32'(exp_addr));
      if (i == ready_lat - 1) chan_ready_i = 1'b1;
    end
    tick();
    chan_ready_i = 1'b0;
    chk("valid_drop", 32'(chan_valid_o), 32'd0);
    if (respond) begin
      for (int i = 0; i < rsp_lat; i++) tick();
      chan_rsp_valid_i = 1'b1;
      chan_rsp_data_i  = d;
      sb.push_back('{v: oh, d: d, e: 1'b0, at: cyc + 1});
      tick();
      chan_rsp_valid_i = 1'b0;
      chan_rsp_data_i  = '0;
    end else begin
      sb.push_back('{v: oh, d: '0, e: 1'b1, at: ci + TIMEOUT + 1});
      while (cyc < ci + TIMEOUT + 1) tick();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int ci;
    int c0;
    int prev_done;
    int order [5];
    order = '{0, 1, 2, 3, 0};

    rst              = 1'b1;
    req_i            = '0;
    req_addr_i       = '0;
    chan_ready_i     = 1'b0;
    chan_rsp_valid_i = 1'b0;
    chan_rsp_data_i  = '0;
    tick();
    tick();
    check_quiet("reset");
    rst = 1'b0;
    tick();

    // Single requester, minimum latency.
    req_addr_i = {4'h1, 4'h9, 4'h3, 4'h5};
    req_i      = 4'b0100;
    c0         = cyc;
    serve(2, 4'h9, 0, 0, 1'b1, 8'hA5, ci);
    chk("single_issue_lat", 32'(ci - c0), 32'd1);
    req_i = '0;
    tick();
    tick();
    chk("single_idle_busy", 32'(busy_o), 32'd0);

    // Fairness with all requesters held, starting from reset priority.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req_addr_i = {4'hD, 4'hC, 4'hB, 4'hA};
    req_i      = 4'b1111;
    prev_done  = 0;
    for (int j = 0; j < 5; j++) begin
      serve(order[j], 4'(4'hA + order[j]), 0, 0, 1'b1, 8'(8'h10 + j), ci);
      if (j > 0) chk("reissue_gap", 32'(ci - prev_done), 32'd2);
      prev_done = cyc;
    end
    req_i = '0;
    tick();
    tick();

    // Backpressure with an address change after the latch.
    req_addr_i = {4'h7, 4'h0, 4'h0, 4'h0};
    req_i      = 4'b1000;
    tick();
    req_addr_i = {4'hE, 4'h0, 4'h0, 4'h0};
    serve(3, 4'h7, 3, 1, 1'b1, 8'h3C, ci);
    req_i = '0;
    tick();
    tick();

    // Timeout, then a stale response that must be discarded.
    req_addr_i = {4'h0, 4'h0, 4'h0, 4'h2};
    req_i      = 4'b0001;
    serve(0, 4'h2, 0, 0, 1'b0, 8'h00, ci);
    req_i = '0;
    tick();
    tick();
    chan_rsp_valid_i = 1'b1;
    chan_rsp_data_i  = 8'h77;
    tick();
    chan_rsp_valid_i = 1'b0;
    chan_rsp_data_i  = '0;
    repeat (3) tick();
    chk("stale_busy", 32'(busy_o), 32'd0);

    // Response in the same cycle as timer expiry in WAIT.
    req_addr_i = {4'h0, 4'h0, 4'h4, 4'h0};
    req_i      = 4'b0010;
    serve(1, 4'h4, 0, TIMEOUT - 1, 1'b1, 8'h5A, ci);
    req_i = '0;
    tick();
    tick();

    // Reset during WAIT: no pulse, late response ignored, priority restored.
    req_addr_i = {4'h0, 4'h0, 4'h6, 4'h0};
    req_i      = 4'b0010;
    wait_valid();
    chan_ready_i = 1'b1;
    tick();
    chan_ready_i = 1'b0;
    chk("wait_busy", 32'(busy_o), 32'd1);
    rst = 1'b1;
    tick();
    check_quiet("midreset");
    rst              = 1'b0;
    req_i            = '0;
    chan_rsp_valid_i = 1'b1;
    chan_rsp_data_i  = 8'hEE;
    tick();
    chan_rsp_valid_i = 1'b0;
    chan_rsp_data_i  = '0;
    repeat (3) tick();
    chk("late_rsp_busy", 32'(busy_o), 32'd0);
    req_addr_i = {4'hD, 4'hC, 4'hB, 4'hA};
    req_i      = 4'b1111;
    serve(0, 4'hA, 0, 0, 1'b1, 8'h42, ci);
    req_i = '0;
    repeat (3) tick();

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
